// File: rtl/wb_select_stage.sv
// Writeback select: N-way source mux, load lane extract/extend, zero-reg and misalign handling, retire counter.
// Latency: one cycle from an accepted request (wb_req & ~stall) to reg_wdata/reg_waddr/reg_we/misalign.
// Backpressure: stall freezes every output register, stretching any pulse; wb_req is ignored while stalled.
module wb_select_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int MEM_SRC = 1,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32,
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int OFF_W  = $clog2(WIDTH / 8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         wb_sel,
  input  logic                     wb_req,
  input  logic [REG_AW-1:0]        dest_reg,
  input  logic [1:0]               load_size,
  input  logic                     load_unsigned,
  input  logic [OFF_W-1:0]         byte_offset,
  input  logic                     stall,
  output logic [WIDTH-1:0]         reg_wdata,
  output logic [REG_AW-1:0]        reg_waddr,
  output logic                     reg_we,
  output logic                     misalign,
  output logic [CNT_W-1:0]         wb_count
);

  localparam int SH_W = 7;

  logic [WIDTH-1:0]        sel_dat;
  logic [WIDTH-1:0]        raw_dat;
  logic [WIDTH-1:0]        lane_dat;
  logic [WIDTH-1:0]        shifted;
  logic [WIDTH-1:0]        zext_dat;
  logic signed [WIDTH-1:0] sext_dat;
  logic [WIDTH-1:0]        next_dat;
  logic [SH_W-1:0]         sh;
  logic                    is_mem;
  logic                    bad_align;
  logic                    next_mis;
  logic                    commit;

  // Plain source mux; an out-of-range select yields zero data.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (wb_sel == SEL_W'(k)) sel_dat = src_data[k*WIDTH +: WIDTH];
    end
  end

  // Memory lane extraction: shift the wanted lane to the top, then shift back
  // logically or arithmetically to get zero or sign extension for any lane width.
  always_comb begin
    raw_dat  = src_data[MEM_SRC*WIDTH +: WIDTH];
    lane_dat = raw_dat >> {byte_offset, 3'b000};
    case (load_size)
      2'b00:   sh = SH_W'(WIDTH - 8);
      2'b01:   sh = SH_W'(WIDTH - 16);
      2'b10:   sh = SH_W'(WIDTH - 32);
      default: sh = '0;
    endcase
    shifted  = lane_dat << sh;
    zext_dat = shifted >> sh;
    sext_dat = $signed(shifted) >>> sh;
  end

  // Alignment check and final writeback decision for this cycle's request.
  always_comb begin
    case (load_size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = byte_offset[0];
      2'b10:   bad_align = |byte_offset[1:0];
      default: bad_align = |byte_offset;
    endcase
    is_mem   = (wb_sel == SEL_W'(MEM_SRC));
    next_mis = is_mem & bad_align;
    next_dat = is_mem ? (load_unsigned ? zext_dat : WIDTH'(sext_dat)) : sel_dat;
    commit   = ~next_mis & (dest_reg != '0);
  end

  // Output registers: load on accept, drop pulses when idle, hold everything on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_wdata <= '0;
      reg_waddr <= '0;
      reg_we    <= 1'b0;
      misalign  <= 1'b0;
      wb_count  <= '0;
    end else if (!stall) begin
      if (wb_req) begin
        reg_wdata <= next_dat;
        reg_waddr <= dest_reg;
        reg_we    <= commit;
        misalign  <= next_mis;
        if (commit) wb_count <= wb_count + 1'b1;
      end else begin
        reg_we   <= 1'b0;
        misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed steps followed by random traffic against a reference model.
// NUM_SRC=5 so a 3-bit selector can express out-of-range sources (5..7).
module tb_wb_select_stage;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 5;
  localparam int MEM_SRC = 1;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 32;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [2:0]               wb_sel = '0;
  logic                     wb_req = 1'b0;
  logic [REG_AW-1:0]        dest_reg = '0;
  logic [1:0]               load_size = '0;
  logic                     load_unsigned = 1'b0;
  logic [1:0]               byte_offset = '0;
  logic                     stall = 1'b0;
  logic [WIDTH-1:0]         reg_wdata;
  logic [REG_AW-1:0]        reg_waddr;
  logic                     reg_we;
  logic                     misalign;
  logic [CNT_W-1:0]         wb_count;

  logic [31:0] src_m [NUM_SRC];

  // reference state
  logic [31:0] e_wdata;
  logic [4:0]  e_waddr;
  logic        e_we;
  logic        e_mis;
  longint      e_cnt;

  int total = 0;
  int bad   = 0;

  wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .MEM_SRC(MEM_SRC),
                    .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .wb_sel(wb_sel),
    .wb_req(wb_req), .dest_reg(dest_reg), .load_size(load_size),
    .load_unsigned(load_unsigned), .byte_offset(byte_offset), .stall(stall),
    .reg_wdata(reg_wdata), .reg_waddr(reg_waddr), .reg_we(reg_we),
    .misalign(misalign), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) src_data[k*WIDTH +: WIDTH] = src_m[k];
  end

  function automatic int lane_bits(input logic [1:0] sz);
    case (sz)
      2'd0: return 8;
      2'd1: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input int sel, input logic [1:0] sz,
                                           input logic uns, input int off);
    longint unsigned lane, mask, v;
    int nb;
    if (sel >= NUM_SRC) return 32'd0;
    if (sel != MEM_SRC) return src_m[sel];
    nb   = lane_bits(sz);
    lane = longint'(src_m[MEM_SRC]) >> (8 * off);
    mask = (64'd1 << nb) - 1;
    v    = lane & mask;
    if (!uns && ((v >> (nb - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic ref_mis(input int sel, input logic [1:0] sz, input int off);
    if (sel != MEM_SRC) return 1'b0;
    return (off % (lane_bits(sz) / 8)) != 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_wdata = '0; e_waddr = '0; e_we = 1'b0; e_mis = 1'b0; e_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    64'(reg_we),    64'(e_we));
    chk({tag, ".mis"},   64'(misalign),  64'(e_mis));
    chk({tag, ".wdata"}, 64'(reg_wdata), 64'(e_wdata));
    chk({tag, ".waddr"}, 64'(reg_waddr), 64'(e_waddr));
    chk({tag, ".cnt"},   64'(wb_count),  64'(e_cnt[31:0]));
  endtask

  // one clock: advance the model with the inputs present at the edge, then compare
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset && !stall) begin
      if (wb_req) begin
        e_wdata = ref_data(int'(wb_sel), load_size, load_unsigned, int'(byte_offset));
        e_waddr = dest_reg;
        e_mis   = ref_mis(int'(wb_sel), load_size, int'(byte_offset));
        e_we    = !e_mis && dest_reg != 0;
        if (e_we) e_cnt = (e_cnt + 1) % (64'd1 << 32);
      end else begin
        e_we = 1'b0; e_mis = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int sel, input logic req, input int dst, input int sz,
                       input logic uns, input int off, input logic stl);
    wb_sel = 3'(sel); wb_req = req; dest_reg = 5'(dst); load_size = 2'(sz);
    load_unsigned = uns; byte_offset = 2'(off); stall = stl;
  endtask

  initial begin
    for (int k = 0; k < NUM_SRC; k++) src_m[k] = 32'h0;
    model_reset();
    #1;
    check_all("reset0");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ALU write to r5
    src_m[0] = 32'h1234_5678;
    drive(0, 1, 5, 0, 0, 0, 0);
    tick("alu");
    chk("alu_const", 64'({reg_we, reg_waddr, reg_wdata}), {27'd0, 1'b1, 5'd5, 32'h1234_5678});
    drive(0, 0, 5, 0, 0, 0, 0);
    tick("alu_idle");
    chk("alu_cnt", 64'(wb_count), 64'd1);

    // signed / unsigned byte loads
    src_m[1] = 32'h80FF_7F01;
    drive(1, 1, 7, 0, 0, 3, 0);
    tick("lb3");
    chk("lb3_const", 64'(reg_wdata), 64'h0000_0000_FFFF_FF80);
    drive(1, 1, 7, 0, 1, 1, 0);
    tick("lbu1");
    chk("lbu1_const", 64'(reg_wdata), 64'h0000_0000_0000_007F);

    // halfword alignment
    drive(1, 1, 8, 1, 0, 1, 0);
    tick("lh_mis");
    chk("lh_mis_const", 64'({misalign, reg_we}), 64'b10);
    src_m[1] = 32'h8001_0000;
    drive(1, 1, 8, 1, 0, 2, 0);
    tick("lh2");
    chk("lh2_const", 64'({reg_we, reg_wdata}), {31'd0, 1'b1, 32'hFFFF_8001});

    // zero register, then out-of-range select
    drive(0, 1, 0, 0, 0, 0, 0);
    tick("r0");
    drive(7, 1, 3, 0, 0, 0, 0);
    tick("oor");
    chk("oor_const", 64'({reg_we, reg_wdata}), {31'd0, 1'b1, 32'h0});

    // stall hold: write r9, stall three cycles with a competing request, release with a new one
    src_m[2] = 32'hCAFE_0009;
    drive(2, 1, 9, 0, 0, 0, 0);
    tick("st_acc");
    src_m[2] = 32'hDEAD_BEEF;
    drive(2, 1, 4, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_hold", 64'({reg_we, reg_waddr}), {58'd0, 1'b1, 5'd9});
    end
    drive(2, 1, 10, 0, 0, 0, 0);
    tick("st_rel");
    chk("st_rel_const", 64'(reg_waddr), 64'd10);

    // async reset while reg_we is high, between edges
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("post_rst");

    // random traffic
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < NUM_SRC; k++) src_m[k] = $urandom;
      drive(int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
